// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares one integer ALU between two requesters. A round-robin arbiter picks
// one valid requester in IDLE and accepts its operation with a valid/ready
// handshake. The operands are latched into registers that drive the ALU and
// stay stable for the whole EXEC state. This is what makes the multi-cycle
// MUL path safe. The ALU result is then presented on a single tagged
// response channel until the consumer takes it.
//
// Optional build macro: ALU_SHARE_STATS_EN
//   When defined, adds the per-requester grant counters grant_cnt0_o and
//   grant_cnt1_o. Each counter is 16 bits and saturates at 16'hFFFF.
//
// Parameters
//   MUL_CYCLES  cycles the operands are held for MUL (ctrl 4'b0101), 1..15
//   WIDTH       operand / result width
//
// Ports
//   clk_i                 rising-edge clock
//   rst_i                 asynchronous, active-high reset
//   req0_valid_i          requester 0 has an operation
//   req0_ready_o          requester 0 accepted this cycle (combinational)
//   req0_ctrl_i           requester 0 ALU control code
//   req0_data0_i          requester 0 operand 0
//   req0_data1_i          requester 0 operand 1
//   req1_*                same set of ports for requester 1
//   rsp_valid_o           result available
//   rsp_ready_i           consumer takes the result
//   rsp_id_o              requester that owns the result
//   rsp_data_o            result value
//   alu_data0_o           operand 0 to the ALU
//   alu_data1_o           operand 1 to the ALU
//   alu_ctrl_o            control code to the ALU
//   alu_data_i            result from the ALU
//   grant_cnt0_o          (stats build only) handshakes granted to requester 0
//   grant_cnt1_o          (stats build only) handshakes granted to requester 1
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int MUL_CYCLES = 3,
    parameter int WIDTH      = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    output logic             req0_ready_o,
    input  logic [3:0]       req0_ctrl_i,
    input  logic [WIDTH-1:0] req0_data0_i,
    input  logic [WIDTH-1:0] req0_data1_i,
    input  logic             req1_valid_i,
    output logic             req1_ready_o,
    input  logic [3:0]       req1_ctrl_i,
    input  logic [WIDTH-1:0] req1_data0_i,
    input  logic [WIDTH-1:0] req1_data1_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic             rsp_id_o,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic [WIDTH-1:0] alu_data0_o,
    output logic [WIDTH-1:0] alu_data1_o,
    output logic [3:0]       alu_ctrl_o,
    input  logic [WIDTH-1:0] alu_data_i
`ifdef ALU_SHARE_STATS_EN
    ,
    output logic [15:0]      grant_cnt0_o,
    output logic [15:0]      grant_cnt1_o
`endif
);

    localparam logic [3:0] CTRL_MUL = 4'b0101;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic             r_rr_ptr;
    logic [3:0]       r_cnt;
    logic             r_id;
    logic [3:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_alu_d0;
    logic [WIDTH-1:0] r_alu_d1;
    logic             r_rsp_valid;
    logic             r_rsp_id;
    logic [WIDTH-1:0] r_rsp_data;

    logic             w_grant;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_accept;
    logic             w_capture;
    logic             w_release;
    logic [3:0]       w_acc_ctrl;
    logic [WIDTH-1:0] w_acc_d0;
    logic [WIDTH-1:0] w_acc_d1;

    // Grant selection: a lone valid requester always wins; on contention the
    // round-robin pointer decides.
    always_comb begin
        w_grant = r_rr_ptr;
        if (req0_valid_i && !req1_valid_i) begin
            w_grant = 1'b0;
        end else if (req1_valid_i && !req0_valid_i) begin
            w_grant = 1'b1;
        end
    end

    // Payload of the granted requester, sampled only on the handshake edge.
    always_comb begin
        w_acc_ctrl = w_grant ? req1_ctrl_i  : req0_ctrl_i;
        w_acc_d0   = w_grant ? req1_data0_i : req0_data0_i;
        w_acc_d1   = w_grant ? req1_data1_i : req0_data1_i;
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and handshake outputs. The readys are gated by rst_i so
    // that nothing is offered or accepted while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_capture   = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready0 = !rst_i && req0_valid_i && !w_grant;
                w_ready1 = !rst_i && req1_valid_i &&  w_grant;
                if (w_ready0 || w_ready1) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (r_rsp_valid && rsp_ready_i) begin
                    w_release   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = w_ready0 || w_ready1;

    // Operand latch, hold counter and round-robin pointer. The ALU operand
    // registers are only written on a handshake, so they keep their last
    // values through IDLE and stay stable for all of EXEC.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rr_ptr   <= 1'b0;
            r_cnt      <= 4'd0;
            r_id       <= 1'b0;
            r_alu_ctrl <= 4'd0;
            r_alu_d0   <= '0;
            r_alu_d1   <= '0;
        end else if (w_accept) begin
            r_alu_ctrl <= w_acc_ctrl;
            r_alu_d0   <= w_acc_d0;
            r_alu_d1   <= w_acc_d1;
            r_id       <= w_grant;
            r_rr_ptr   <= ~w_grant;
            r_cnt      <= (w_acc_ctrl == CTRL_MUL) ? MUL_LOAD : 4'd0;
        end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Response register: captured at the end of EXEC and held until taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
        end else if (w_capture) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= alu_data_i;
        end else if (w_release) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_SHARE_STATS_EN
    logic [15:0] r_gcnt0;
    logic [15:0] r_gcnt1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gcnt0 <= 16'd0;
            r_gcnt1 <= 16'd0;
        end else begin
            if (w_ready0 && (r_gcnt0 != 16'hFFFF)) begin
                r_gcnt0 <= r_gcnt0 + 16'd1;
            end
            if (w_ready1 && (r_gcnt1 != 16'hFFFF)) begin
                r_gcnt1 <= r_gcnt1 + 16'd1;
            end
        end
    end

    assign grant_cnt0_o = r_gcnt0;
    assign grant_cnt1_o = r_gcnt1;
`endif

    assign req0_ready_o = w_ready0;
    assign req1_ready_o = w_ready1;
    assign rsp_valid_o  = r_rsp_valid;
    assign rsp_id_o     = r_rsp_id;
    assign rsp_data_o   = r_rsp_data;
    assign alu_data0_o  = r_alu_d0;
    assign alu_data1_o  = r_alu_d1;
    assign alu_ctrl_o   = r_alu_ctrl;

endmodule
